// File: rtl/mul_seq_ctrl.sv
// Sequential shift-add multiplier controller for the EX stage.
// One multiplier bit per cycle for exactly WIDTH cycles; freezes the front end while it runs.
module mul_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             set_s,
  input  logic             flush,
  input  logic [WIDTH-1:0] val_rn,
  input  logic [WIDTH-1:0] val_rm,
  output logic             freeze,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             status_we,
  output logic [3:0]       status
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] mcand, mplier, acc, acc_sum;
  logic [CW-1:0]    cnt;
  logic             s_q;
  logic             accept, last;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    accept    = start && !flush && (state == IDLE || state == DONE);
    last      = (state == RUN) && (cnt == CW'(WIDTH - 1));
    acc_sum   = mplier[0] ? acc + mcand : acc;
    busy      = (state == RUN);
    done      = (state == DONE);
    status_we = done && s_q;
    freeze    = accept || busy;
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (accept) state_nxt = RUN;
        RUN:     if (last)   state_nxt = DONE;
        DONE:    state_nxt = accept ? RUN : IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      s_q    <= 1'b0;
      result <= '0;
      status <= 4'b0000;
    end else if (accept) begin
      mcand  <= val_rn;
      mplier <= val_rm;
      acc    <= '0;
      cnt    <= '0;
      s_q    <= set_s;
    end else if (state == RUN && !flush) begin
      acc    <= acc_sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      // The final add is folded into result directly so DONE sees it without an extra cycle.
      if (last) begin
        result <= acc_sum;
        if (s_q) status <= {2'b00, acc_sum[WIDTH-1], (acc_sum == '0)};
      end
    end
  end

endmodule

// File: doc/mul_seq_ctrl.md
MUL_SEQ_CTRL -- requirements
Module: mul_seq_ctrl

Interface
REQ-001 Parameter: WIDTH, 32, operand, accumulator and result width.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 start  in  1  EX stage issues a MUL; sampled only when ready to accept.
REQ-005 set_s  in  1  S-bit of the issuing MUL; captured with start.
REQ-006 flush  in  1  pipeline flush; aborts any multiply in progress.
REQ-007 val_rn  in  WIDTH  multiplicand; captured with start.
REQ-008 val_rm  in  WIDTH  multiplier; captured with start.
REQ-009 freeze  out  1  stalls IF/ID/EX pipeline registers while high.
REQ-010 busy  out  1  high while in RUN.
REQ-011 done  out  1  single-cycle pulse; result valid.
REQ-012 result  out  WIDTH  low WIDTH bits of val_rn*val_rm; held until next done.
REQ-013 status_we  out  1  single-cycle pulse with done when captured set_s=1.
REQ-014 status  out  4  {C,V,N,Z}, valid while status_we is high.

Function
REQ-015 FSM SHALL have three states: IDLE, RUN, DONE.
REQ-016 Accept: start=1 and flush=0 in IDLE or DONE SHALL load mcand=val_rn, mplier=val_rm, acc=0, cnt=0, s_q=set_s, and go to RUN.
REQ-017 RUN, each cycle: if mplier[0] then acc<=acc+mcand (mod 2^WIDTH); mcand<<=1; mplier>>=1; cnt<=cnt+1.
REQ-018 RUN SHALL last exactly WIDTH cycles regardless of operand values; no early termination.
REQ-019 On the RUN cycle with cnt=WIDTH-1, SHALL go to DONE and load result with the final acc, including that cycle's add.
REQ-020 DONE SHALL last one cycle with done=1; it goes to RUN on an accepted start, otherwise to IDLE.
REQ-021 Latency: start accepted at cycle T gives done at T+WIDTH+1, which is T+33 for WIDTH=32.
REQ-022 freeze SHALL equal (accepting start combinationally) OR (state==RUN); freeze=0 in the DONE cycle unless a new start is accepted.
REQ-023 busy SHALL be 1 exactly in RUN.
REQ-024 start in RUN SHALL be ignored; the EX stage holds it under freeze.
REQ-025 status: N=result[WIDTH-1], Z=(result==0), C=0, V=0.
REQ-026 status_we=done AND s_q; status SHALL hold its value when status_we=0.
REQ-027 flush in any state SHALL force IDLE next cycle with no done/status_we pulse; result and status unchanged; flush has priority over start.
REQ-028 Operands with bit WIDTH-1 set SHALL be treated as unsigned bit patterns; the low-WIDTH result is identical for signed operands.

Reset
REQ-029 reset SHALL force IDLE; result=0, status=0, done=0, status_we=0, busy=0, freeze=0, acc=0, cnt=0, s_q=0.
REQ-030 reset has priority over flush and start; reset mid-RUN SHALL discard the operation with no done pulse.
REQ-031 The first start is accepted on the first cycle after reset deasserts.

Verification
REQ-032 start, rn=7, rm=6, set_s=1 -> freeze high for 33 cycles; done at T+33; result=42; status_we=1; status=4'b0000.
REQ-033 rn=0xFFFFFFFF, rm=2, set_s=1 -> result=0xFFFFFFFE, N=1, Z=0; rn=0x10000, rm=0x10000 -> result=0, Z=1.
REQ-034 set_s=0, rn=3, rm=5 -> done with result=15, status_we=0, status unchanged.
REQ-035 flush at cycle T+10 of a RUN -> IDLE at T+11; no done pulse; result keeps its prior value; freeze=0.
REQ-036 start held high during DONE (rn=2, rm=9 after a 3x4 op) -> done with result=12, immediate RUN, next done 33 cycles later with result=18; start pulses during RUN ignored.
REQ-037 reset asserted at RUN cycle 20 -> all outputs 0 next cycle; a new start one cycle later completes normally.
